// File: rtl/button_input.sv
// Push-button front end: per-channel two-flop synchroniser, debounce filter,
// and press/release/auto-repeat pulse generation in the clk60 domain.
module button_input #(
  parameter int unsigned NUM_BTN         = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 600000,
  parameter int unsigned REPEAT_DELAY    = 30000000,
  parameter int unsigned REPEAT_PERIOD   = 6000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned DW   = (DEBOUNCE_CYCLES >= 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned RW   = (RMAX >= 1) ? $clog2(RMAX + 1) : 1;
  localparam bit          REPEAT_EN = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } state_e;

  logic [NUM_BTN-1:0] pin;
  logic [NUM_BTN-1:0] s1_q, s1_d;
  logic [NUM_BTN-1:0] s2_q, s2_d;
  logic [NUM_BTN-1:0] db_q, db_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] repeat_q, repeat_d;
  logic [DW-1:0]      dcnt_q [NUM_BTN];
  logic [DW-1:0]      dcnt_d [NUM_BTN];
  logic [RW-1:0]      rcnt_q [NUM_BTN];
  logic [RW-1:0]      rcnt_d [NUM_BTN];
  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];

  // Internal polarity is always 1 = pressed.
  assign pin = ACTIVE_LOW ? ~btn_in : btn_in;

  // State register for synchroniser, debounce and repeat logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        dcnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  // Next-state: debounce acceptance, then the per-channel repeat FSM.
  always_comb begin
    s1_d      = pin;
    s2_d      = s1_q;
    db_d      = db_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      dcnt_d[i]  = '0;
      rcnt_d[i]  = rcnt_q[i];
      state_d[i] = state_q[i];

      if (s2_q[i] != db_q[i]) begin
        if (dcnt_q[i] + DW'(1) == DW'(DEBOUNCE_CYCLES)) begin
          db_d[i]      = s2_q[i];
          press_d[i]   = s2_q[i];
          release_d[i] = ~s2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end

      // A release always wins over a repeat that falls due in the same cycle.
      case (state_q[i])
        IDLE: begin
          rcnt_d[i] = '0;
          if (press_d[i]) begin
            state_d[i] = HELD;
          end
        end
        HELD: begin
          if (release_d[i]) begin
            state_d[i] = IDLE;
            rcnt_d[i]  = '0;
          end else if (REPEAT_EN && (rcnt_q[i] + RW'(1) == RW'(REPEAT_DELAY))) begin
            repeat_d[i] = 1'b1;
            state_d[i]  = REPEAT;
            rcnt_d[i]   = '0;
          end else if (rcnt_q[i] != RW'(RMAX)) begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        REPEAT: begin
          if (release_d[i]) begin
            state_d[i] = IDLE;
            rcnt_d[i]  = '0;
          end else if (rcnt_q[i] + RW'(1) == RW'(REPEAT_PERIOD)) begin
            repeat_d[i] = 1'b1;
            rcnt_d[i]   = '0;
          end else if (rcnt_q[i] != RW'(RMAX)) begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          rcnt_d[i]  = '0;
        end
      endcase
    end
  end

  assign btn_level   = db_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_input.sv
// Bench for button_input: per-cycle scoreboard of expected level/pulse vectors
// built from event times, on an active-low and an active-high instance.
module tb_button_input;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  typedef struct packed {
    logic       rst;
    logic [1:0] pa;
    logic [1:0] pb;
  } stim_t;

  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] rep;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pa, pb;
  logic [1:0] lvl_a, prs_a, rel_a, rep_a;
  logic [1:0] lvl_b, prs_b, rel_b, rep_b;
  obs_t       obs_a, obs_b;

  int checks = 0;
  int errors = 0;

  stim_t stim_q[$];
  obs_t  exp_q[$];

  always #5 clk = ~clk;

  button_input #(.NUM_BTN(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .rst(rst), .btn_in(pa), .btn_level(lvl_a),
    .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rep_a));

  button_input #(.NUM_BTN(2), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DB),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .rst(rst), .btn_in(pb), .btn_level(lvl_b),
    .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rep_b));

  assign obs_a = {lvl_a, prs_a, rel_a, rep_a};
  assign obs_b = {lvl_b, prs_b, rel_b, rep_b};

  // Pin held pressed for sampled cycles a..b-1.
  function automatic logic pressed(int k, int a, int b);
    return (k >= a) && (k < b);
  endfunction

  // Expected {level, press, release, repeat} for cycle k of a single press interval.
  function automatic logic [3:0] model(int k, int a, int b);
    int p, r;
    logic [3:0] m;
    p = a + DB + 1;
    r = b + DB + 1;
    m = 4'b0000;
    if (b - a >= DB) begin
      m[3] = (k >= p) && (k < r);
      m[2] = (k == p);
      m[1] = (k == r);
      m[0] = (k > p) && (k < r) && (k - p >= RD) && (((k - p - RD) % RP) == 0);
    end
    return m;
  endfunction

  function automatic obs_t pack2(logic [3:0] c0, logic [3:0] c1);
    obs_t r;
    r.lvl = {c1[3], c0[3]};
    r.prs = {c1[2], c0[2]};
    r.rel = {c1[1], c0[1]};
    r.rep = {c1[0], c0[0]};
    return r;
  endfunction

  task automatic push(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Entered at a negedge; drives one cycle and returns at the following negedge.
  task automatic run_cycle(input stim_t s);
    rst = s.rst;
    pa  = s.pa;
    pb  = s.pb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o, e;
    int k;
    for (int i = 1; i <= 8; i++)
      push('{rst: (i <= 4), pa: 2'b11, pb: 2'b00}, '0);
    k = 0;
    while (stim_q.size() != 0) begin
      k++;
      run_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_a | obs_b;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset cycle %0d got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_clean_press();
    obs_t o, e;
    int k;
    for (int i = 1; i <= 22; i++)
      push('{rst: 1'b0, pa: {1'b1, ~pressed(i, 1, 13)}, pb: 2'b00},
           pack2(model(i, 1, 13), model(i, 0, 0)));
    k = 0;
    while (stim_q.size() != 0) begin
      k++;
      run_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_a;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clean_press cycle %0d got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_glitch();
    obs_t o, e;
    int k;
    for (int i = 1; i <= 26; i++)
      push('{rst: 1'b0, pa: {1'b1, ~(pressed(i, 1, 4) || pressed(i, 13, 17))}, pb: 2'b00},
           pack2(model(i, 1, 4) | model(i, 13, 17), model(i, 0, 0)));
    k = 0;
    while (stim_q.size() != 0) begin
      k++;
      run_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_a;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL glitch cycle %0d got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_repeat();
    obs_t o, e;
    int k, nrep;
    for (int i = 1; i <= 40; i++)
      push('{rst: 1'b0, pa: {1'b1, ~pressed(i, 1, 31)}, pb: 2'b00},
           pack2(model(i, 1, 31), model(i, 0, 0)));
    k = 0;
    nrep = 0;
    while (stim_q.size() != 0) begin
      k++;
      run_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_a;
      if (o.rep[0] === 1'b1) nrep++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL repeat cycle %0d got %h expected %h", k, o, e);
      end
    end
    checks++;
    if (nrep !== 7) begin
      errors++;
      $display("FAIL repeat_count got %0d expected 7", nrep);
    end
  endtask

  task automatic test_collision();
    obs_t o, e;
    int k;
    for (int i = 1; i <= 24; i++)
      push('{rst: 1'b0, pa: {1'b1, ~pressed(i, 1, 14)}, pb: 2'b00},
           pack2(model(i, 1, 14), model(i, 0, 0)));
    k = 0;
    while (stim_q.size() != 0) begin
      k++;
      run_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_a;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL collision cycle %0d got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    obs_t o, e;
    int k;
    for (int i = 1; i <= 48; i++) begin
      if (i < 18)
        e = pack2(model(i, 1, 1000), model(i, 0, 0));
      else if (i <= 19)
        e = '0;
      else
        e = pack2(model(i, 20, 40), model(i, 0, 0));
      push('{rst: (i == 18 || i == 19), pa: {1'b1, ~pressed(i, 1, 40)}, pb: 2'b00}, e);
    end
    k = 0;
    while (stim_q.size() != 0) begin
      k++;
      run_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_a;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_hold cycle %0d got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_polarity();
    obs_t o, e;
    int k;
    for (int i = 1; i <= 30; i++)
      push('{rst: 1'b0, pa: 2'b11, pb: {pressed(i, 1, 20), pressed(i, 1, 12)}},
           pack2(model(i, 1, 12), model(i, 1, 20)));
    k = 0;
    while (stim_q.size() != 0) begin
      k++;
      run_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_b;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL polarity cycle %0d got %h expected %h", k, o, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pa  = 2'b11;
    pb  = 2'b00;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_repeat();
    test_collision();
    test_reset_mid_hold();
    test_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
